key_emulator: RTL and testbench

Drives a debounced-style level key signal from one-cycle press requests: each accepted request becomes exactly one clean key-down interval of fixed length followed by a mandatory key-up gap. It sits upstream of the keypress edge detector, feeding its leftkey or rightkey input. Typical sources are the computer-player logic or a self-test sequencer, so one request always yields exactly one leftpress/rightpress pulse downstream. One instance serves one key; the tug-of-war top instantiates two.

---
 rtl/key_emulator_pkg.sv | 20 ++
 rtl/key_emulator.sv | 126 ++++++++++++
 tb/tb_key_emulator.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_emulator_pkg.sv
// Shared types and helpers for the key emulator.
//   state_t   : controller state encoding (IDLE, HOLD, GAP)
//   cnt_width : width of the shared HOLD/GAP interval counter
package key_emulator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Bits needed to hold max(hold, gap) - 1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned gap);
    int unsigned m;
    m = (hold > gap) ? hold : gap;
    if (m <= 1) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/key_emulator.sv
// Key emulator: turns one-cycle press requests into clean key-down intervals
// of HOLD_CYCLES followed by a key-up gap of at least GAP_CYCLES. Requests
// arriving while a press is in progress are counted (up to DEPTH) and
// replayed back to back; requests beyond that are dropped.
// Ports:
//   clk      : system clock
//   reset    : synchronous, active-high reset
//   req      : press request, one request per high cycle
//   key      : emulated key level (1 = pressed), flop output
//   done     : one-cycle pulse on the first key-up cycle after a press
//   overflow : one-cycle pulse the cycle after a request was dropped
//   pending  : accepted requests not yet started
//   busy     : press/gap in progress or requests queued
module key_emulator
  import key_emulator_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned DEPTH       = 7,
  localparam int unsigned CW         = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  output logic          key,
  output logic          done,
  output logic          overflow,
  output logic [CW-1:0] pending,
  output logic          busy
);

  localparam int unsigned TW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] pending_q, pending_d;
  logic          key_q, key_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic          launch;
  logic          work;

  // State, counter, queue and output flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= '0;
      key_q     <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      key_q     <= key_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state, interval counter and request queue accounting.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    key_d     = key_q;
    done_d    = 1'b0;
    ovf_d     = 1'b0;
    launch    = 1'b0;
    work      = req || (pending_q != '0);

    case (state_q)
      IDLE: begin
        if (work) launch = 1'b1;
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - TW'(1);
        end else begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
          key_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q != '0) cnt_d = cnt_q - TW'(1);
        else if (work)   launch = 1'b1;
        else             state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        key_d   = 1'b0;
      end
    endcase

    // A launch consumes either the live request or one queued request; when
    // both are present the live request takes the vacated queue slot.
    if (launch) begin
      state_d = HOLD;
      cnt_d   = HOLD_LOAD;
      key_d   = 1'b1;
      if (!req) pending_d = pending_q - CW'(1);
    end else if (req) begin
      if (pending_q != DEPTH_C) pending_d = pending_q + CW'(1);
      else                      ovf_d     = 1'b1;
    end

    busy_d = (state_d != IDLE) || (pending_d != '0);
  end

  assign key      = key_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign pending  = pending_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_key_emulator.sv
// Testbench for key_emulator: a fixed vector table for single and burst
// presses, hand-written corner sequences, and randomized traffic checked
// against a schedule-based model (each accepted request gets a start time).
module tb_key_emulator;

  localparam int H = 4;
  localparam int G = 2;
  localparam int P = H + G;
  localparam int D = 7;

  logic       clk;
  logic       reset;
  logic       req;
  logic       key;
  logic       done;
  logic       overflow;
  logic [2:0] pending;
  logic       busy;

  key_emulator #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .DEPTH(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .key      (key),
    .done     (done),
    .overflow (overflow),
    .pending  (pending),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model: start times of accepted requests
  int starts[$];
  int last_start = -1000;
  int cyc = 0;
  logic exp_ovf = 1'b0;
  int accepted = 0;
  int dropped = 0;
  int done_seen = 0;
  int ovf_seen = 0;

  function automatic bit has_start(input int t);
    foreach (starts[i]) if (starts[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int count_ge(input int t);
    int c = 0;
    foreach (starts[i]) if (starts[i] >= t) c++;
    return c;
  endfunction

  task automatic model_edge(input int t, input logic r, input logic rst);
    int cand;
    exp_ovf = 1'b0;
    if (rst) begin
      starts.delete();
      last_start = -1000;
      return;
    end
    while (starts.size() > 0 && starts[0] + P < t) void'(starts.pop_front());
    if (r) begin
      cand = (last_start + P > t) ? last_start + P : t;
      if (cand == t || has_start(t) || count_ge(t) < D) begin
        starts.push_back(cand);
        last_start = cand;
        accepted++;
      end else begin
        exp_ovf = 1'b1;
        dropped++;
      end
    end
  endtask

  task automatic expect_at(input int t, output logic k, output logic d,
                           output logic b, output logic [2:0] p);
    int pc = 0;
    k = 1'b0; d = 1'b0; b = 1'b0;
    foreach (starts[i]) begin
      if (starts[i] <= t && t < starts[i] + H) k = 1'b1;
      if (t == starts[i] + H) d = 1'b1;
      if (starts[i] <= t && t < starts[i] + P) b = 1'b1;
      if (starts[i] > t) pc++;
    end
    p = 3'(pc);
    if (pc > 0) b = 1'b1;
  endtask

  // ---------------- downstream keypress stand-in: 2-flop sync + rise detect
  logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  logic leftpress;
  int   lp_count = 0;
  int   lp_wide = 0;
  logic lp_prev = 1'b0;

  always @(posedge clk) begin
    s1 <= key;
    s2 <= s1;
    s3 <= s2;
  end
  assign leftpress = s2 & ~s3;

  always @(negedge clk) begin
    if (leftpress) lp_count <= lp_count + 1;
    if (leftpress && lp_prev) lp_wide <= lp_wide + 1;
    lp_prev <= leftpress;
  end

  // ---------------- comparison helpers
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic ek, input logic ed,
                         input logic eo, input logic [2:0] ep, input logic eb);
    n_vec++;
    if ({key, done, overflow, pending, busy} !== {ek, ed, eo, ep, eb}) begin
      n_err++;
      $display("FAIL %s cyc=%0d got key=%b done=%b ovf=%b pend=%0d busy=%b expected key=%b done=%b ovf=%b pend=%0d busy=%b",
               name, cyc, key, done, overflow, pending, busy, ek, ed, eo, ep, eb);
    end
  endtask

  task automatic step(input logic r, input logic rst);
    req   = r;
    reset = rst;
    @(posedge clk);
    cyc++;
    model_edge(cyc, r, rst);
    @(negedge clk);
    if (done === 1'b1) done_seen++;
    if (overflow === 1'b1) ovf_seen++;
  endtask

  task automatic mstep(input logic r, input logic rst, input string name);
    logic k, d, b;
    logic [2:0] p;
    step(r, rst);
    expect_at(cyc, k, d, b, p);
    chk_out(name, k, d, exp_ovf, p, b);
  endtask

  task automatic drain(input string name, input int limit);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin
      mstep(1'b0, 1'b0, name);
      n++;
    end
    if (n >= limit) chk({name, "_timeout"}, 1, 0);
  endtask

  // ---------------- vector table
  typedef struct packed {
    logic       r;
    logic       rst;
    logic       k;
    logic       d;
    logic       o;
    logic [2:0] p;
    logic       b;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rst, input logic k,
                              input logic d, input logic o, input int p, input logic b);
    vec_t v;
    v.r = r; v.rst = rst; v.k = k; v.d = d; v.o = o; v.p = 3'(p); v.b = b;
    return v;
  endfunction

  vec_t tbl[30];

  initial begin
    int d0, o0, a0, lp0, issued, gap, blen;
    logic busy_low;

    req   = 1'b0;
    reset = 1'b1;

    // reset, then a single request, then a burst of three
    tbl[0]  = mk(0, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 1, 0, 0, 0, 1);
    tbl[4]  = mk(0, 0, 1, 0, 0, 0, 1);
    tbl[5]  = mk(0, 0, 1, 0, 0, 0, 1);
    tbl[6]  = mk(0, 0, 1, 0, 0, 0, 1);
    tbl[7]  = mk(0, 0, 0, 1, 0, 0, 1);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 1);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 0, 1, 0, 0, 0, 1);
    tbl[12] = mk(1, 0, 1, 0, 0, 1, 1);
    tbl[13] = mk(1, 0, 1, 0, 0, 2, 1);
    tbl[14] = mk(0, 0, 1, 0, 0, 2, 1);
    tbl[15] = mk(0, 0, 0, 1, 0, 2, 1);
    tbl[16] = mk(0, 0, 0, 0, 0, 2, 1);
    tbl[17] = mk(0, 0, 1, 0, 0, 1, 1);
    tbl[18] = mk(0, 0, 1, 0, 0, 1, 1);
    tbl[19] = mk(0, 0, 1, 0, 0, 1, 1);
    tbl[20] = mk(0, 0, 1, 0, 0, 1, 1);
    tbl[21] = mk(0, 0, 0, 1, 0, 1, 1);
    tbl[22] = mk(0, 0, 0, 0, 0, 1, 1);
    tbl[23] = mk(0, 0, 1, 0, 0, 0, 1);
    tbl[24] = mk(0, 0, 1, 0, 0, 0, 1);
    tbl[25] = mk(0, 0, 1, 0, 0, 0, 1);
    tbl[26] = mk(0, 0, 1, 0, 0, 0, 1);
    tbl[27] = mk(0, 0, 0, 1, 0, 0, 1);
    tbl[28] = mk(0, 0, 0, 0, 0, 0, 1);
    tbl[29] = mk(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      step(tbl[i].r, tbl[i].rst);
      chk_out($sformatf("table[%0d]", i), tbl[i].k, tbl[i].d, tbl[i].o, tbl[i].p, tbl[i].b);
    end

    // overflow: the second launch at +6 frees a slot, so the tenth
    // consecutive request is the first one dropped
    d0 = done_seen; o0 = ovf_seen;
    for (int i = 0; i < 10; i++) mstep(1'b1, 1'b0, "ovf_burst");
    chk("ovf_pulse", int'(overflow), 1);
    chk("ovf_pending", int'(pending), 7);
    drain("ovf_drain", 200);
    chk("ovf_pulse_count", ovf_seen - o0, 1);
    chk("ovf_press_count", done_seen - d0, 9);

    // request on the final GAP edge relaunches with no idle cycle
    mstep(1'b0, 1'b0, "bnd_idle");
    busy_low = 1'b0;
    mstep(1'b1, 1'b0, "bnd_first");
    for (int i = 0; i < 5; i++) begin
      mstep(1'b0, 1'b0, "bnd_wait");
      if (busy !== 1'b1) busy_low = 1'b1;
    end
    chk("bnd_key_low_before", int'(key), 0);
    mstep(1'b1, 1'b0, "bnd_relaunch");
    chk("bnd_key_relaunch", int'(key), 1);
    chk("bnd_no_idle", int'(busy_low), 0);
    drain("bnd_drain", 50);

    // reset in the middle of HOLD with three queued requests
    for (int i = 0; i < 4; i++) mstep(1'b1, 1'b0, "rst_fill");
    chk("rst_pending_before", int'(pending), 3);
    chk("rst_key_before", int'(key), 1);
    d0 = done_seen;
    mstep(1'b0, 1'b1, "rst_apply");
    chk_out("rst_outputs", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 30; i++) mstep(1'b0, 1'b0, "rst_quiet");
    chk("rst_no_press", done_seen - d0, 0);

    // loopback into the keypress stand-in, random spacing with bursts
    a0 = accepted; lp0 = lp_count; issued = 0;
    while (issued < 20) begin
      gap = int'($urandom_range(0, 10));
      for (int i = 0; i < gap; i++) mstep(1'b0, 1'b0, "loop_idle");
      blen = int'($urandom_range(1, 4));
      for (int j = 0; j < blen && issued < 20; j++) begin
        mstep(1'b1, 1'b0, "loop_req");
        issued++;
      end
    end
    drain("loop_drain", 400);
    for (int i = 0; i < 5; i++) mstep(1'b0, 1'b0, "loop_tail");
    chk("loop_press_count", lp_count - lp0, accepted - a0);
    chk("loop_press_width", lp_wide, 0);

    // dense random traffic with rare resets
    for (int i = 0; i < 600; i++) begin
      mstep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 199) == 0), "random");
    end
    drain("random_drain", 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
